// File: rtl/trap_pkg.sv
// Shared types and cause codes for the machine-mode trap sequencer.
// The optional timer interrupt is enabled by defining TRAP_TIMER_IRQ_EN.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2,
        REDIR  = 2'd3
    } trap_state_t;

    localparam int CAUSE_ILLEGAL     = 2;
    localparam int CAUSE_EBREAK      = 3;
    localparam int CAUSE_LOAD_FAULT  = 5;
    localparam int CAUSE_STORE_FAULT = 7;
    localparam int CAUSE_ECALL       = 11;
    localparam int CAUSE_MTIMER      = 7;

    function automatic bit cause_fits(input int code, input int width);
        return code < (1 << width);
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-point, CSR and IFU redirect signals of trap_ctrl bundled as one interface.
// TRAP_TIMER_IRQ_EN adds the timer interrupt level and mstatus.MIE inputs.
interface trap_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
);
    logic               i_valid;
    logic [XLEN-1:0]    i_pc;
    logic               i_illegal;
    logic               i_ecall;
    logic               i_ebreak;
    logic               i_mret;
    logic               i_lsu_fault;
    logic               i_lsu_store;
    logic               i_lsu_busy;
    logic [XLEN-1:0]    i_mtvec;
    logic [XLEN-1:0]    i_mepc;
`ifdef TRAP_TIMER_IRQ_EN
    logic               i_irq_timer;
    logic               i_mie;
`endif
    logic               o_stall;
    logic               o_csr_valid;
    logic               o_exception;
    logic               o_mret;
    logic [CAUSE_W-1:0] o_mcause;
    logic [XLEN-1:0]    o_epc;
    logic               o_interrupt;
    logic               o_redirect_valid;
    logic [XLEN-1:0]    o_redirect_pc;
    logic               i_redirect_ready;
    logic               o_timeout;

    modport slave (
        input  i_valid, i_pc, i_illegal, i_ecall, i_ebreak, i_mret,
               i_lsu_fault, i_lsu_store, i_lsu_busy, i_mtvec, i_mepc,
`ifdef TRAP_TIMER_IRQ_EN
               i_irq_timer, i_mie,
`endif
               i_redirect_ready,
        output o_stall, o_csr_valid, o_exception, o_mret, o_mcause, o_epc,
               o_interrupt, o_redirect_valid, o_redirect_pc, o_timeout
    );

    modport master (
        output i_valid, i_pc, i_illegal, i_ecall, i_ebreak, i_mret,
               i_lsu_fault, i_lsu_store, i_lsu_busy, i_mtvec, i_mepc,
`ifdef TRAP_TIMER_IRQ_EN
               i_irq_timer, i_mie,
`endif
               i_redirect_ready,
        input  o_stall, o_csr_valid, o_exception, o_mret, o_mcause, o_epc,
               o_interrupt, o_redirect_valid, o_redirect_pc, o_timeout
    );
endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority selection among trap sources at the commit point:
// illegal > ecall > ebreak > load fault > store fault > interrupt > mret.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int CAUSE_W = 4
) (
    input  logic               i_valid,
    input  logic               i_illegal,
    input  logic               i_ecall,
    input  logic               i_ebreak,
    input  logic               i_lsu_fault,
    input  logic               i_lsu_store,
    input  logic               i_irq,
    input  logic               i_mret,
    output logic               o_take,
    output logic               o_is_mret,
    output logic               o_is_irq,
    output logic [CAUSE_W-1:0] o_cause
);

    if (!(cause_fits(CAUSE_ILLEGAL, CAUSE_W) && cause_fits(CAUSE_EBREAK, CAUSE_W) &&
          cause_fits(CAUSE_LOAD_FAULT, CAUSE_W) && cause_fits(CAUSE_STORE_FAULT, CAUSE_W) &&
          cause_fits(CAUSE_ECALL, CAUSE_W) && cause_fits(CAUSE_MTIMER, CAUSE_W))) begin : g_cause_w_err
        $error("trap_prio_enc: CAUSE_W too narrow for the cause codes");
    end

    always_comb begin
        o_take    = 1'b0;
        o_is_mret = 1'b0;
        o_is_irq  = 1'b0;
        o_cause   = '0;
        if (i_valid) begin
            o_take = 1'b1;
            if (i_illegal)
                o_cause = CAUSE_W'(CAUSE_ILLEGAL);
            else if (i_ecall)
                o_cause = CAUSE_W'(CAUSE_ECALL);
            else if (i_ebreak)
                o_cause = CAUSE_W'(CAUSE_EBREAK);
            else if (i_lsu_fault && !i_lsu_store)
                o_cause = CAUSE_W'(CAUSE_LOAD_FAULT);
            else if (i_lsu_fault)
                o_cause = CAUSE_W'(CAUSE_STORE_FAULT);
            else if (i_irq) begin
                o_is_irq = 1'b1;
                o_cause  = CAUSE_W'(CAUSE_MTIMER);
            end else if (i_mret)
                o_is_mret = 1'b1;
            else
                o_take = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer: detect, drain LSU, CSR strobe, IFU redirect.
// Define TRAP_TIMER_IRQ_EN to add the machine timer interrupt source.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CAUSE_W   = 4,
    parameter int DRAIN_MAX = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    trap_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    if (DRAIN_MAX < 1) begin : g_drain_max_err
        $error("trap_ctrl: DRAIN_MAX must be at least 1");
    end

    trap_state_t        r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_is_mret;
    logic               r_is_irq;
    logic [XLEN-1:0]    r_epc;
    logic [XLEN-1:0]    r_target;
    logic               r_timeout;

    logic               w_irq;
    logic               w_take;
    logic               w_is_mret;
    logic               w_is_irq;
    logic [CAUSE_W-1:0] w_cause;
    logic               w_set_timeout;
    logic               w_commit;
    logic               w_redir;

`ifdef TRAP_TIMER_IRQ_EN
    assign w_irq = bus.i_irq_timer & bus.i_mie;
`else
    assign w_irq = 1'b0;
`endif

    trap_prio_enc #(.CAUSE_W(CAUSE_W)) u_prio (
        .i_valid     (bus.i_valid && (r_state == IDLE)),
        .i_illegal   (bus.i_illegal),
        .i_ecall     (bus.i_ecall),
        .i_ebreak    (bus.i_ebreak),
        .i_lsu_fault (bus.i_lsu_fault),
        .i_lsu_store (bus.i_lsu_store),
        .i_irq       (w_irq),
        .i_mret      (bus.i_mret),
        .o_take      (w_take),
        .o_is_mret   (w_is_mret),
        .o_is_irq    (w_is_irq),
        .o_cause     (w_cause)
    );

    always_comb begin
        w_next        = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            IDLE:   if (w_take) w_next = DRAIN;
            // busy dropping on the last counted cycle is a clean drain, not a timeout
            DRAIN: begin
                if (!bus.i_lsu_busy)
                    w_next = COMMIT;
                else if (r_cnt == CNT_W'(DRAIN_MAX - 1)) begin
                    w_next        = COMMIT;
                    w_set_timeout = 1'b1;
                end
            end
            COMMIT: w_next = REDIR;
            REDIR:  if (bus.i_redirect_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cause   <= '0;
            r_is_mret <= 1'b0;
            r_is_irq  <= 1'b0;
            r_epc     <= '0;
            r_target  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_timeout)
                r_timeout <= 1'b1;
            case (r_state)
                IDLE: if (w_take) begin
                    r_cause   <= w_cause;
                    r_is_mret <= w_is_mret;
                    r_is_irq  <= w_is_irq;
                    r_epc     <= bus.i_pc;
                    r_cnt     <= '0;
                end
                DRAIN:  r_cnt    <= r_cnt + CNT_W'(1);
                COMMIT: r_target <= r_is_mret ? bus.i_mepc : bus.i_mtvec;
                default: ;
            endcase
        end
    end

    assign w_commit = (r_state == COMMIT);
    assign w_redir  = (r_state == REDIR);

    assign bus.o_stall          = (r_state != IDLE) || w_take;
    assign bus.o_csr_valid      = w_commit;
    assign bus.o_exception      = w_commit && !r_is_mret;
    assign bus.o_mret           = w_commit && r_is_mret;
    assign bus.o_mcause         = w_commit ? r_cause : '0;
    assign bus.o_epc            = w_commit ? r_epc : '0;
    assign bus.o_interrupt      = w_commit && r_is_irq;
    assign bus.o_redirect_valid = w_redir;
    assign bus.o_redirect_pc    = w_redir ? r_target : '0;
    assign bus.o_timeout        = r_timeout;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: stimulus pushes expected CSR/redirect records,
// a negedge monitor pops and compares them whenever the strobe fires.
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam logic [31:0] MTVEC = 32'h8000_0100;
    localparam logic [31:0] MEPC  = 32'h8000_0014;

    typedef struct {
        logic        exc;
        logic        mr;
        logic        irq;
        logic [3:0]  cause;
        logic [31:0] epc;
        logic [31:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] mon_tgt = '0;
    bit   mon_have_tgt = 1'b0;
    int   n;
    int   rcnt;

    trap_ctrl_if #(.XLEN(32), .CAUSE_W(4)) bus();

    trap_ctrl #(.XLEN(32), .CAUSE_W(4), .DRAIN_MAX(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic exc, input logic mr, input logic irq,
                            input logic [3:0] cause, input logic [31:0] epc,
                            input logic [31:0] tgt);
        exp_t e;
        e.exc = exc; e.mr = mr; e.irq = irq; e.cause = cause; e.epc = epc; e.tgt = tgt;
        exp_q.push_back(e);
    endtask

    task automatic clear_req();
        bus.i_valid = 1'b0; bus.i_illegal = 1'b0; bus.i_ecall = 1'b0; bus.i_ebreak = 1'b0;
        bus.i_mret = 1'b0; bus.i_lsu_fault = 1'b0; bus.i_lsu_store = 1'b0;
    endtask

    task automatic drive(input logic il, input logic ec, input logic eb, input logic mr,
                         input logic lf, input logic ls, input logic [31:0] pc);
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.i_illegal = il; bus.i_ecall = ec; bus.i_ebreak = eb;
        bus.i_mret = mr; bus.i_lsu_fault = lf; bus.i_lsu_store = ls; bus.i_pc = pc;
    endtask

    // Called in the detect cycle; returns cycles from detect until o_stall drops.
    task automatic finish_txn(input bit hold, input int ready_delay, input int busy_cycles,
                              output int cyc, output int redir_cycles);
        bit seen = 1'b0;
        cyc = 0;
        redir_cycles = 0;
        bus.i_lsu_busy = (busy_cycles > 0);
        bus.i_redirect_ready = (ready_delay == 0);
        @(negedge clk);
        chk("detect_stall", bus.o_stall, 1);
        forever begin
            @(posedge clk); #1;
            if (!hold || seen) clear_req();
            bus.i_lsu_busy = (cyc + 1 < busy_cycles);
            bus.i_redirect_ready = (redir_cycles >= ready_delay);
            @(negedge clk);
            cyc++;
            if (bus.o_redirect_valid) begin
                seen = 1'b1;
                redir_cycles++;
            end
            if (!bus.o_stall) break;
            if (cyc >= 300) begin
                chk("txn_bound", 1, 0);
                break;
            end
        end
        clear_req();
        bus.i_lsu_busy = 1'b0;
        bus.i_redirect_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_have_tgt <= 1'b0;
        end else begin
            if (bus.o_csr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("exception", bus.o_exception, e.exc);
                    chk("mret", bus.o_mret, e.mr);
                    chk("interrupt", bus.o_interrupt, e.irq);
                    chk("mcause", bus.o_mcause, e.cause);
                    chk("epc", bus.o_epc, e.epc);
                    mon_tgt <= e.tgt;
                    mon_have_tgt <= 1'b1;
                end
            end else begin
                chk("idle_csr_fields", {bus.o_exception, bus.o_mret, bus.o_interrupt,
                                        bus.o_mcause, bus.o_epc}, 0);
            end
            if (bus.o_redirect_valid) begin
                if (!mon_have_tgt) chk("redirect_without_commit", 1, 0);
                else               chk("redirect_pc", bus.o_redirect_pc, mon_tgt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_req();
        bus.i_pc = '0;
        bus.i_lsu_busy = 1'b0;
        bus.i_mtvec = MTVEC;
        bus.i_mepc = MEPC;
        bus.i_redirect_ready = 1'b1;
`ifdef TRAP_TIMER_IRQ_EN
        bus.i_irq_timer = 1'b0;
        bus.i_mie = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.o_stall, bus.o_csr_valid, bus.o_redirect_valid,
                              bus.o_redirect_pc, bus.o_timeout, bus.o_mcause}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // valid low: flags must be ignored
        @(posedge clk); #1;
        bus.i_ecall = 1'b1; bus.i_illegal = 1'b1;
        @(negedge clk);
        chk("no_valid_no_stall", bus.o_stall, 0);
        clear_req();

        // ecall, fastest path
        push_exp(1, 0, 0, 4'd11, 32'h8000_0010, MTVEC);
        drive(0, 1, 0, 0, 0, 0, 32'h8000_0010);
        finish_txn(0, 0, 0, n, rcnt);
        chk("ecall_turnaround", n, 4);

        // illegal+ecall+load fault held through the whole sequence
        push_exp(1, 0, 0, 4'd2, 32'h8000_0020, MTVEC);
        drive(1, 1, 0, 0, 1, 0, 32'h8000_0020);
        finish_txn(1, 0, 0, n, rcnt);
        chk("prio_turnaround", n, 4);
        repeat (2) @(negedge clk);
        chk("prio_no_retrap", bus.o_stall, 0);

        // ebreak beats store fault
        push_exp(1, 0, 0, 4'd3, 32'h8000_0030, MTVEC);
        drive(0, 0, 1, 0, 1, 1, 32'h8000_0030);
        finish_txn(0, 0, 0, n, rcnt);

        // store fault beats mret
        push_exp(1, 0, 0, 4'd7, 32'h8000_0034, MTVEC);
        drive(0, 0, 0, 1, 1, 1, 32'h8000_0034);
        finish_txn(0, 0, 0, n, rcnt);

        // mret with IFU back-pressure for 3 cycles
        push_exp(0, 1, 0, 4'd0, 32'h8000_0040, MEPC);
        drive(0, 0, 0, 1, 0, 0, 32'h8000_0040);
        finish_txn(0, 3, 0, n, rcnt);
        chk("mret_redir_cycles", rcnt, 4);
        chk("mret_turnaround", n, 7);

        // load fault, LSU busy for 5 cycles
        push_exp(1, 0, 0, 4'd5, 32'h8000_0050, MTVEC);
        drive(0, 0, 0, 0, 1, 0, 32'h8000_0050);
        finish_txn(0, 0, 5, n, rcnt);
        chk("drain5_turnaround", n, 8);
        chk("drain5_no_timeout", bus.o_timeout, 0);

        // LSU busy stuck: forced commit after DRAIN_MAX=8
        push_exp(1, 0, 0, 4'd5, 32'h8000_0060, MTVEC);
        drive(0, 0, 0, 0, 1, 0, 32'h8000_0060);
        finish_txn(0, 0, 1000, n, rcnt);
        chk("timeout_turnaround", n, 11);
        chk("timeout_sticky", bus.o_timeout, 1);

        // reset while redirect is pending
        push_exp(1, 0, 0, 4'd11, 32'h8000_0070, MTVEC);
        bus.i_redirect_ready = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 32'h8000_0070);
        @(posedge clk); #1 clear_req();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_redirect_valid && n < 20);
        chk("reach_redir", bus.o_redirect_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_in_redir", {bus.o_stall, bus.o_csr_valid, bus.o_redirect_valid,
                               bus.o_redirect_pc, bus.o_timeout, bus.o_mcause, bus.o_epc}, 0);
        @(posedge clk); #1 rst = 1'b0; bus.i_redirect_ready = 1'b1;
        push_exp(1, 0, 0, 4'd11, 32'h8000_0080, MTVEC);
        drive(0, 1, 0, 0, 0, 0, 32'h8000_0080);
        finish_txn(0, 0, 0, n, rcnt);
        chk("post_reset_turnaround", n, 4);

`ifdef TRAP_TIMER_IRQ_EN
        bus.i_irq_timer = 1'b1; bus.i_mie = 1'b1;
        push_exp(1, 0, 1, 4'd7, 32'h8000_0090, MTVEC);
        drive(0, 0, 0, 0, 0, 0, 32'h8000_0090);
        finish_txn(0, 0, 0, n, rcnt);
        chk("irq_turnaround", n, 4);

        push_exp(1, 0, 0, 4'd11, 32'h8000_00a0, MTVEC);
        drive(0, 1, 0, 0, 0, 0, 32'h8000_00a0);
        finish_txn(0, 0, 0, n, rcnt);

        push_exp(1, 0, 1, 4'd7, 32'h8000_00b0, MTVEC);
        drive(0, 0, 0, 1, 0, 0, 32'h8000_00b0);
        finish_txn(0, 0, 0, n, rcnt);

        bus.i_mie = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h8000_00c0);
        @(negedge clk);
        chk("irq_masked_no_stall", bus.o_stall, 0);
        clear_req();
        bus.i_irq_timer = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and mret return around the CSR file.
- Arbitrates simultaneous trap sources from decode/LSU by fixed priority and stalls the pipeline while the LSU drains.
- Issues a one-cycle CSR update strobe (mcause/mepc) and then a PC redirect handshake to IFU.
- Sits between IDU/LSU, the CSR file and the IFU.

Parameters:
- XLEN, 32, data/PC width.
- CAUSE_W, 4, width of the mcause code sent to the CSR file.
- DRAIN_MAX, 255, maximum cycles spent waiting for i_lsu_busy to fall before forcing commit.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_valid  in  1  instruction at commit point this cycle.
- i_pc  in  XLEN  PC of that instruction.
- i_illegal, i_ecall, i_ebreak, i_mret  in  1 each  decode flags.
- i_lsu_fault  in  1  LSU access fault for this instruction.
- i_lsu_store  in  1  fault was a store (else load).
- i_lsu_busy  in  1  LSU transaction outstanding.
- i_mtvec, i_mepc  in  XLEN  current CSR values.
- o_stall  out  1  freeze the pipeline.
- o_csr_valid  out  1  one-cycle CSR update strobe.
- o_exception  out  1  strobe is a trap entry.
- o_mret  out  1  strobe is an mret.
- o_mcause  out  CAUSE_W  cause code.
- o_epc  out  XLEN  PC to save in mepc.
- o_interrupt  out  1  cause is an interrupt.
- o_redirect_valid  out  1  redirect request to IFU.
- o_redirect_pc  out  XLEN  redirect target.
- i_redirect_ready  in  1  IFU accepts the redirect.
- o_timeout  out  1  sticky: drain hit DRAIN_MAX.

Behaviour:
- Reset: state IDLE. All outputs 0, including o_timeout and the drain counter. Latched cause, epc and target are cleared to 0.
- Reset mid-operation returns to IDLE next edge. A pending redirect is dropped and no CSR strobe is issued.
- Trap detect (IDLE only, requires i_valid): the highest asserted source wins, in this order:
  - illegal → 2
  - ecall → 11
  - ebreak → 3
  - load fault → 5
  - store fault → 7
- mret is taken only when no trap source is asserted. A trap always wins over a simultaneous mret.
- o_stall is combinational: 1 when state≠IDLE, or when in IDLE with a trap or mret detected this cycle.
- Request flags are ignored outside IDLE.
- FSM states: IDLE, DRAIN, COMMIT, REDIR.
- IDLE → DRAIN on detect. Latch cause, kind (trap/mret) and o_epc←i_pc. Clear the drain counter.
- DRAIN → COMMIT on the first cycle where i_lsu_busy=0. Minimum 1 cycle in DRAIN.
- The drain counter increments each DRAIN cycle. When it reaches DRAIN_MAX, go to COMMIT regardless and set o_timeout (cleared only by reset).
- COMMIT lasts exactly 1 cycle:
  - o_csr_valid=1.
  - Trap: o_exception=1, o_mcause=latched cause. Latch target←i_mtvec.
  - mret: o_mret=1, o_mcause=0. Latch target←i_mepc.
  - Then go to REDIR.
- REDIR: o_redirect_valid=1 and o_redirect_pc=target, both held stable until i_redirect_ready=1. On that cycle go to IDLE; o_stall deasserts the following cycle.
- The earliest turnaround from detect to IDLE is 4 cycles, with ready already high.
- o_mcause, o_epc and o_interrupt are valid only while o_csr_valid=1 and are 0 otherwise.
- Width rules:
  - Cause codes are zero-extended to CAUSE_W.
  - A code ≥2^CAUSE_W is a parameter error, caught by an elaboration-time check.

Optional Feature:
- Macro: TRAP_TIMER_IRQ_EN.
- Enabled: adds ports i_irq_timer (1, level) and i_mie (1, mstatus.MIE).
  - In IDLE with i_valid, i_irq_timer & i_mie, and no synchronous trap, take interrupt cause 7 with o_interrupt=1.
  - epc=i_pc; the instruction is not executed.
  - A synchronous trap has priority over the interrupt; an interrupt has priority over mret.
- Disabled: the ports are absent and o_interrupt is tied to 0.

Decomposition:
- Package trap_pkg holds:
  - the state enum (IDLE/DRAIN/COMMIT/REDIR);
  - cause constants CAUSE_ILLEGAL=2, CAUSE_EBREAK=3, CAUSE_LOAD_FAULT=5, CAUSE_STORE_FAULT=7, CAUSE_ECALL=11, CAUSE_MTIMER=7.
- One sub-module, trap_prio_enc: combinational priority encoder from the source flags to {take, is_mret, is_irq, cause}.
- The FSM, drain counter and latches stay in trap_ctrl.

Test Plan:
- ecall at pc=0x80000010, mtvec=0x80000100, lsu idle, ready=1 → COMMIT strobe with mcause=11, epc=0x80000010; redirect to 0x80000100; back in IDLE 4 cycles after detect.
- illegal+ecall+load fault together → mcause=2 only; one strobe; no second trap taken.
- mret with mepc=0x80000014, ready low for 3 cycles → o_mret strobe with o_exception=0; redirect valid and 0x80000014 held stable for 4 cycles.
- Load fault with i_lsu_busy high for 5 cycles → stays in DRAIN 5 cycles, then mcause=5 strobe; o_timeout=0. Repeat with busy stuck and DRAIN_MAX=8 → commit after 8 cycles, o_timeout=1.
- Reset asserted during REDIR → next cycle all outputs 0, state IDLE; a later ecall is processed normally.
- TRAP_TIMER_IRQ_EN: irq=1, mie=1, no trap → mcause=7, o_interrupt=1. irq together with ecall → mcause=11, o_interrupt=0. irq=1, mie=0 → no action.
